issue_scheduler: RTL

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler_pkg.sv | 29 ++
 rtl/instr_fifo.sv | 52 +++++
 rtl/issue_scheduler.sv | 96 +++++++++
 3 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the in-order issue scheduler: RV32I field
// positions, the bubble encoding and the issue FSM state encoding.
package issue_scheduler_pkg;

  // RV32I register field bit positions
  localparam int RS1_HI = 19;
  localparam int RS1_LO = 15;
  localparam int RS2_HI = 24;
  localparam int RS2_LO = 20;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 7;

  // All-zero word driven on Instr_out when nothing issues
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Issue FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef logic [4:0] reg_idx_t;

  // Control bits that travel with each queued instruction
  typedef struct packed {
    logic reg_write;
    logic alu_src;
  } ctrl_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding queued instructions. Head is read combinationally
// from storage, so a word written this cycle is visible at the head no
// earlier than the next cycle.
module instr_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/issue_scheduler.sv
// In-order single-issue scheduler: queues instructions, tracks pending
// register writes with a per-register countdown, and holds the queue head
// until its source registers are no longer pending.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int Instruction_word_size = 32,
  parameter int bs  = 16,
  parameter int LAT = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [Instruction_word_size-1:0] Instr_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             RegWrite,
  input  logic                             ALUSrc,
  output logic [Instruction_word_size-1:0] Instr_out,
  output logic                             out_valid,
  output logic [15:0]                      stall_cnt
);
  localparam int         EW    = Instruction_word_size + $bits(ctrl_t);
  localparam logic [2:0] LAT_C = 3'(LAT);

  logic                             full, empty;
  logic [EW-1:0]                    head;
  logic [Instruction_word_size-1:0] head_instr;
  ctrl_t                            head_ctrl;
  reg_idx_t                         rs1, rs2, rd;
  logic [31:0][2:0]                 sb_cnt;
  logic                             hazard, sb_load;
  logic [1:0]                       state;

  assign in_ready = !full && !rst;

  instr_fifo #(.WIDTH(EW), .DEPTH(bs)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid && in_ready),
    .wr_data ({Instr_in, RegWrite, ALUSrc}),
    .rd_en   (state == ST_ISSUE),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign head_instr = head[EW-1 -: Instruction_word_size];
  assign head_ctrl  = head[$bits(ctrl_t)-1:0];
  assign rs1        = head_instr[RS1_HI:RS1_LO];
  assign rs2        = head_instr[RS2_HI:RS2_LO];
  assign rd         = head_instr[RD_HI:RD_LO];

  // Hazard check at the queue head and per-cycle state selection
  always_comb begin
    hazard = (sb_cnt[rs1] != '0) || (!head_ctrl.alu_src && (sb_cnt[rs2] != '0));
    if (empty)       state = ST_IDLE;
    else if (hazard) state = ST_STALL;
    else             state = ST_ISSUE;
  end

  assign sb_load = (state == ST_ISSUE) && head_ctrl.reg_write && (rd != '0);

  // Scoreboard: load LAT on issue of a writer, otherwise count down; x0 stays 0
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_cnt <= '0;
    end else begin
      sb_cnt[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        if (sb_load && rd == reg_idx_t'(i)) sb_cnt[i] <= LAT_C;
        else if (sb_cnt[i] != '0)           sb_cnt[i] <= sb_cnt[i] - 3'd1;
      end
    end
  end

  // Issue register: head instruction on ISSUE, bubble otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      Instr_out <= '0;
      out_valid <= 1'b0;
    end else if (state == ST_ISSUE) begin
      Instr_out <= head_instr;
      out_valid <= 1'b1;
    end else begin
      Instr_out <= Instruction_word_size'(NOP_INSTR);
      out_valid <= 1'b0;
    end
  end

  // Saturating count of cycles spent stalled on a hazard
  always_ff @(posedge clk) begin
    if (rst)                                          stall_cnt <= '0;
    else if (state == ST_STALL && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

endmodule
